// File: rtl/frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// frame_scheduler_pkg
// Shared definitions for the frame scheduler slice:
//   state_t      scheduler FSM states
//   BLACK        colour driven to the VGA port during the erase pass
//   TMO_DEFAULT  default watchdog limit (cycles) for a client's done
// ---------------------------------------------------------------------------
package frame_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_STEP
  } state_t;

  localparam logic [2:0]  BLACK       = 3'b000;
  localparam logic [19:0] TMO_DEFAULT = 20'd4095;

endpackage

// File: rtl/frame_watchdog.sv
// ---------------------------------------------------------------------------
// frame_watchdog
// Resettable saturating up-counter with a terminal-count flag. The scheduler
// clears it while a client is being started and lets it count while waiting
// for that client's done.
//   clk, resetn  clock, asynchronous active-low reset
//   clear        synchronous clear (wins over en)
//   en           count enable
//   limit        terminal count value
//   tc           high while count == limit
// ---------------------------------------------------------------------------
module frame_watchdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Sequences one animation frame over NCLIENT draw clients and owns the single
// VGA plot port. Each tick runs an erase pass (colour forced to black), pulses
// step, then runs a colour draw pass. Clients are handshaked with start/done.
// While loading is high the loader drives the VGA port directly and any
// frame in progress is dropped.
//   clk, resetn                       clock, asynchronous active-low reset
//   tick                              frame request pulse
//   loading, load_x/y/colour/plot     brick loader override and its pixel
//   start / done                      one-hot client start, client finished
//   cl_x/cl_y/cl_colour/cl_plot       packed client pixels (client i at i*W)
//   vga_x/vga_y/vga_colour/vga_plot   registered pixel to the VGA adapter
//   erase, step, busy                 pass indicator, logic step, not IDLE
//   timeout_err, overrun              sticky error flags
// ---------------------------------------------------------------------------
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int          NCLIENT = 3,
  parameter int          XW      = 10,
  parameter int          CW      = 3,
  parameter logic [19:0] TMO     = TMO_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  tick,
  input  logic                  loading,
  input  logic [XW-1:0]         load_x,
  input  logic [XW-1:0]         load_y,
  input  logic [CW-1:0]         load_colour,
  input  logic                  load_plot,
  output logic [NCLIENT-1:0]    start,
  input  logic [NCLIENT-1:0]    done,
  input  logic [NCLIENT*XW-1:0] cl_x,
  input  logic [NCLIENT*XW-1:0] cl_y,
  input  logic [NCLIENT*CW-1:0] cl_colour,
  input  logic [NCLIENT-1:0]    cl_plot,
  output logic [XW-1:0]         vga_x,
  output logic [XW-1:0]         vga_y,
  output logic [CW-1:0]         vga_colour,
  output logic                  vga_plot,
  output logic                  erase,
  output logic                  step,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun
);

  localparam int             IW       = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NCLIENT - 1);

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic          pass, pass_d;     // 0 = erase pass, 1 = draw pass
  logic          wd_clear, wd_en, wd_tc;
  logic          tmo_hit;

  logic [XW-1:0] sel_x, sel_y;
  logic [CW-1:0] sel_colour;

  frame_watchdog #(.W(20)) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (wd_clear),
    .en     (wd_en),
    .limit  (TMO - 20'd1),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      idx   <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      pass  <= pass_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    pass_d   = pass;
    start    = '0;
    step     = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    tmo_hit  = 1'b0;

    case (state)
      S_IDLE: begin
        if (tick) begin
          state_d = S_START;
          idx_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_START: begin
        start    = NCLIENT'(1) << idx;
        wd_clear = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        // done on the threshold cycle still counts as done
        if (done[idx]) begin
          state_d = S_NEXT;
        end else if (wd_tc) begin
          tmo_hit = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx < LAST_IDX) begin
          idx_d   = idx + IW'(1);
          state_d = S_START;
        end else if (!pass) begin
          state_d = S_STEP;
        end else begin
          idx_d   = '0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        step    = 1'b1;
        pass_d  = 1'b1;
        idx_d   = '0;
        state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase

    // The loader preempts everything: drop the frame and park in IDLE.
    if (loading) begin
      state_d = S_IDLE;
      idx_d   = '0;
      pass_d  = 1'b0;
      tmo_hit = 1'b0;
    end
  end

  assign busy  = (state != S_IDLE);
  assign erase = ~pass & busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tmo_hit) timeout_err <= 1'b1;
      if (tick && busy && !loading) overrun <= 1'b1;
    end
  end

  // Pick the active client's pixel with constant-index slices.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (idx == IW'(i)) begin
        sel_x      = cl_x[i*XW +: XW];
        sel_y      = cl_y[i*XW +: XW];
        sel_colour = cl_colour[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (loading) begin
      vga_x      <= load_x;
      vga_y      <= load_y;
      vga_colour <= load_colour;
      vga_plot   <= load_plot;
    end else if (state == S_WAIT) begin
      vga_x      <= sel_x;
      vga_y      <= sel_y;
      vga_colour <= erase ? CW'(BLACK) : sel_colour;
      vga_plot   <= cl_plot[idx];
    end else begin
      vga_plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Bench for frame_scheduler. A frame-level model expands each accepted tick
// into the expected per-cycle timeline from the client done delays and the
// watchdog limit; a compare process checks the DUT against it every cycle.
// Directed frames add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

  localparam int NCLIENT = 3;
  localparam int XW      = 10;
  localparam int CW      = 3;
  localparam int TMO     = 16;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b1;
  logic                  tick = 1'b0;
  logic                  loading = 1'b0;
  logic [XW-1:0]         load_x = XW'(3);
  logic [XW-1:0]         load_y = XW'(4);
  logic [CW-1:0]         load_colour = CW'(2);
  logic                  load_plot = 1'b0;
  logic [NCLIENT-1:0]    start;
  logic [NCLIENT-1:0]    done = '0;
  logic [NCLIENT*XW-1:0] cl_x = '0;
  logic [NCLIENT*XW-1:0] cl_y = '0;
  logic [NCLIENT*CW-1:0] cl_colour = '0;
  logic [NCLIENT-1:0]    cl_plot = '0;
  logic [XW-1:0]         vga_x, vga_y;
  logic [CW-1:0]         vga_colour;
  logic                  vga_plot, erase, step, busy, timeout_err, overrun;

  frame_scheduler #(
    .NCLIENT(NCLIENT), .XW(XW), .CW(CW), .TMO(20'(TMO))
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .loading(loading),
    .load_x(load_x), .load_y(load_y), .load_colour(load_colour),
    .load_plot(load_plot), .start(start), .done(done),
    .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour), .cl_plot(cl_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .erase(erase), .step(step), .busy(busy),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ clients
  // Client i raises done (level) dly[i] cycles after its start and holds it
  // until its next start; dly[i] == 0 means it never answers.
  int cyc = 0;
  int dly [NCLIENT];
  int cnt [NCLIENT];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < NCLIENT; i++) begin
      dly[i] = 1;
      cnt[i] = -1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCLIENT; i++) begin
        if (!resetn) begin
          done[i] = 1'b0;
          cnt[i]  = -1;
        end else if (start[i]) begin
          done[i] = 1'b0;
          cnt[i]  = (dly[i] > 0) ? dly[i] : -1;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) done[i] = 1'b1;
        end
      end
      cl_x[0 +: XW]        = XW'(cyc * 5);
      cl_y[0 +: XW]        = XW'(cyc + 100);
      cl_colour[0 +: CW]   = CW'(cyc);
      cl_plot[0]           = (cyc % 2) == 1;
      cl_x[XW +: XW]       = XW'(7);
      cl_y[XW +: XW]       = XW'(9);
      cl_colour[CW +: CW]  = 3'b101;
      cl_plot[1]           = 1'b1;
      cl_x[2*XW +: XW]     = XW'(cyc * 3 + 1);
      cl_y[2*XW +: XW]     = XW'(cyc * 7);
      cl_colour[2*CW +: CW] = CW'(cyc / 4);
      cl_plot[2]           = (cyc % 3) != 0;
    end
  end

  // -------------------------------------------------------------------- model
  typedef struct {
    logic [NCLIENT-1:0] start;
    logic               step;
    logic               busy;
    logic               erase;
    logic               tmo_set;   // timeout flag visible from this cycle
    int                 widx;      // client being waited on, -1 if none
  } slot_t;

  slot_t tl [$];

  function automatic slot_t idle_slot();
    slot_t s;
    s.start = '0; s.step = 1'b0; s.busy = 1'b0; s.erase = 1'b0;
    s.tmo_set = 1'b0; s.widx = -1;
    return s;
  endfunction

  // One frame: per client a start cycle, W wait cycles, one advance cycle,
  // where W is the done delay, capped at TMO when the client is late/silent.
  task automatic plan_frame();
    slot_t s;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NCLIENT; i++) begin
        bit late;
        int w;
        late = (dly[i] == 0) || (dly[i] > TMO);
        w    = late ? TMO : dly[i];
        s = idle_slot();
        s.busy  = 1'b1;
        s.erase = (p == 0);
        s.start = NCLIENT'(1) << i;
        tl.push_back(s);
        s.start = '0;
        s.widx  = i;
        repeat (w) tl.push_back(s);
        s.widx    = -1;
        s.tmo_set = late;
        tl.push_back(s);
      end
      if (p == 0) begin
        s = idle_slot();
        s.busy = 1'b1; s.erase = 1'b1; s.step = 1'b1;
        tl.push_back(s);
      end
    end
  endtask

  logic          exp_tmo = 1'b0, exp_ovr = 1'b0, ovr_next = 1'b0;
  logic [XW-1:0] ex_x = '0, ex_y = '0;
  logic [CW-1:0] ex_c = '0;
  logic          ex_p = 1'b0;

  initial forever begin
    slot_t cur;
    @(negedge clk);
    if (!resetn) begin
      tl.delete();
      exp_tmo = 1'b0; exp_ovr = 1'b0; ovr_next = 1'b0; ex_p = 1'b0;
    end else begin
      if (tl.size() > 0) cur = tl.pop_front();
      else               cur = idle_slot();
      if (cur.tmo_set) exp_tmo = 1'b1;
      if (ovr_next)    exp_ovr = 1'b1;

      check("start", start, cur.start);
      check("step", step, cur.step);
      check("busy", busy, cur.busy);
      check("erase", erase, cur.erase);
      check("timeout_err", timeout_err, exp_tmo);
      check("overrun", overrun, exp_ovr);
      check("vga_plot", vga_plot, ex_p);
      if (ex_p) begin
        check("vga_x", vga_x, ex_x);
        check("vga_y", vga_y, ex_y);
        check("vga_colour", vga_colour, ex_c);
      end

      // what the VGA port must show next cycle
      if (loading) begin
        ex_x = load_x; ex_y = load_y; ex_c = load_colour; ex_p = load_plot;
      end else if (cur.widx >= 0) begin
        ex_x = cl_x[cur.widx*XW +: XW];
        ex_y = cl_y[cur.widx*XW +: XW];
        ex_c = cur.erase ? '0 : cl_colour[cur.widx*CW +: CW];
        ex_p = cl_plot[cur.widx];
      end else begin
        ex_p = 1'b0;
      end

      ovr_next = tick && cur.busy && !loading;
      if (loading)                   tl.delete();
      else if (tick && !cur.busy)    plan_frame();
    end
  end

  // ---------------------------------------------------------------- stimulus
  int busy_len, step_cnt, tmo_k, ovr_k;
  logic [NCLIENT-1:0] st_log [$];
  logic               er_log [$];
  logic [XW-1:0] lx [100];
  logic [XW-1:0] ly [100];
  logic [CW-1:0] lc [100];
  logic          lp [100];
  logic [NCLIENT-1:0] exp_st [6] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
  logic               exp_er [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Tick once, then log ncyc cycles; k = 0 is the cycle after the tick edge.
  task automatic run_frame(input int ncyc, input int tick2_k,
                           input int load_on, input int load_off);
    busy_len = 0; step_cnt = 0; tmo_k = -1; ovr_k = -1;
    st_log.delete(); er_log.delete();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      tick      = (k == tick2_k);
      loading   = (k >= load_on) && (k < load_off);
      load_plot = (k == load_on);
      @(negedge clk);
      if (busy) busy_len++;
      if (step) step_cnt++;
      if (start != '0) begin
        st_log.push_back(start);
        er_log.push_back(erase);
      end
      if (timeout_err && tmo_k < 0) tmo_k = k;
      if (overrun && ovr_k < 0)     ovr_k = k;
      lx[k] = vga_x; ly[k] = vga_y; lc[k] = vga_colour; lp[k] = vga_plot;
      @(posedge clk); #1;
    end
    tick = 1'b0; loading = 1'b0; load_plot = 1'b0;
  endtask

  initial begin
    // reset state
    #2 resetn = 1'b0;
    #19;
    check("rst_busy", busy, 1'b0);
    check("rst_start", start, '0);
    check("rst_vga_plot", vga_plot, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);

    // A: every client answers 6 cycles after start
    dly = '{6, 6, 6};
    run_frame(60, -1, -1, -1);
    check("A_busy_len", busy_len, 49);
    check("A_steps", step_cnt, 1);
    check("A_nstart", st_log.size(), 6);
    if (st_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("A_start%0d", i), st_log[i], exp_st[i]);
        check($sformatf("A_erase%0d", i), er_log[i], exp_er[i]);
      end
    end
    check("A_erase_x", lx[10], 7);
    check("A_erase_y", ly[10], 9);
    check("A_erase_col", lc[10], 3'b000);
    check("A_erase_plot", lp[10], 1);
    check("A_after_wait_plot", lp[16], 0);
    check("A_draw_col", lc[35], 3'b101);
    check("A_draw_plot", lp[35], 1);
    check("A_tmo", tmo_k, -1);

    // B: boundary delays (1 cycle, exactly TMO) plus a tick while busy
    dly = '{1, 3, TMO};
    run_frame(70, 10, -1, -1);
    check("B_busy_len", busy_len, 53);
    check("B_steps", step_cnt, 1);
    check("B_tmo", tmo_k, -1);
    check("B_ovr_k", ovr_k, 11);

    // C: loader takes over during client 1's erase wait
    dly = '{6, 6, 6};
    run_frame(40, -1, 11, 20);
    check("C_busy_len", busy_len, 12);
    check("C_steps", step_cnt, 0);
    check("C_nstart", st_log.size(), 2);
    check("C_load_x", lx[12], 3);
    check("C_load_y", ly[12], 4);
    check("C_load_col", lc[12], 3'b010);
    check("C_load_plot", lp[12], 1);
    check("C_idle_plot", lp[13], 0);

    // D: client 2 never answers
    dly = '{2, 2, 0};
    run_frame(70, -1, -1, -1);
    check("D_busy_len", busy_len, 53);
    check("D_steps", step_cnt, 1);
    check("D_tmo_k", tmo_k, 25);
    check("D_nstart", st_log.size(), 6);

    // E: asynchronous reset in the middle of a frame
    dly = '{6, 6, 6};
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("E_pre_busy", busy, 1'b1);
    check("E_pre_tmo", timeout_err, 1'b1);
    check("E_pre_ovr", overrun, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("E_busy", busy, 1'b0);
    check("E_erase", erase, 1'b0);
    check("E_start", start, '0);
    check("E_vga", {vga_x, vga_y, vga_colour, vga_plot}, '0);
    check("E_tmo", timeout_err, 1'b0);
    check("E_ovr", overrun, 1'b0);
    @(posedge clk); #2 resetn = 1'b1;
    repeat (3) @(posedge clk);

    // F: shortest handshake after reset
    dly = '{1, 1, 1};
    run_frame(30, -1, -1, -1);
    check("F_busy_len", busy_len, 19);
    check("F_steps", step_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
